// File: rtl/dmem_ctrl.sv
// Load/store sequencer between the CPU memory stage and a word-wide data RAM
// with asynchronous read and synchronous write. Byte and halfword stores are
// performed as read-modify-write. Loads are sign- or zero-extended. Misaligned
// requests are rejected and their address is recorded.
module dmem_ctrl #(
  parameter int unsigned DEPTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [1:0]       size_i,
  input  logic             sext_i,
  input  logic [DEPTH+1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic             ready_o,
  output logic             ack_o,
  output logic             err_o,
  output logic [31:0]      rdata_o,
  output logic [DEPTH+1:0] err_addr_o,
  output logic             ram_ena_o,
  output logic             ram_wena_o,
  output logic [DEPTH-1:0] ram_addr_o,
  output logic [31:0]      ram_wdata_o,
  input  logic [31:0]      ram_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_MERGE,
    S_WRITE
  } state_e;

  state_e           state_q;
  logic [DEPTH+1:0] addr_q;
  logic [1:0]       size_q;
  logic             sext_q;
  logic [31:0]      wdata_q;
  logic [31:0]      merge_q;
  logic             ack_q;
  logic             err_q;
  logic [31:0]      rdata_q;
  logic [DEPTH+1:0] err_addr_q;

  logic             misaligned;
  logic [31:0]      rdata_d;
  logic [31:0]      merge_d;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;

  assign ready_o     = (state_q == S_IDLE);
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign err_addr_o  = err_addr_q;
  assign ram_ena_o   = (state_q != S_IDLE);
  assign ram_wena_o  = (state_q == S_WRITE);
  assign ram_addr_o  = addr_q[DEPTH+1:2];
  assign ram_wdata_o = (size_q == 2'b10) ? wdata_q : merge_q;

  // Alignment check on the incoming request.
  always_comb begin
    misaligned = 1'b0;
    case (size_i)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_i[0];
      2'b10:   misaligned = (addr_i[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Select the addressed lane of the RAM word and extend it for the load result.
  always_comb begin
    lane_b  = ram_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    lane_h  = ram_rdata_i[{addr_q[1], 4'b0000} +: 16];
    rdata_d = ram_rdata_i;
    case (size_q)
      2'b00:   rdata_d = sext_q ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
      2'b01:   rdata_d = sext_q ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
      default: rdata_d = ram_rdata_i;
    endcase
  end

  // Current RAM word with the target lane replaced by the store data.
  always_comb begin
    merge_d = ram_rdata_i;
    if (size_q == 2'b00) begin
      merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // Sequencer state, latched request and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      sext_q     <= 1'b0;
      wdata_q    <= '0;
      merge_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      err_addr_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            addr_q  <= addr_i;
            size_q  <= size_i;
            sext_q  <= sext_i;
            wdata_q <= wdata_i;
            if (misaligned) begin
              ack_q      <= 1'b1;
              err_q      <= 1'b1;
              err_addr_q <= addr_i;
            end else if (!we_i) begin
              state_q <= S_LOAD;
            end else if (size_i == 2'b10) begin
              state_q <= S_WRITE;
            end else begin
              state_q <= S_MERGE;
            end
          end
        end
        S_LOAD: begin
          rdata_q <= rdata_d;
          ack_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        S_MERGE: begin
          merge_q <= merge_d;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          ack_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, reset-abort and back-to-back
// sequences, then randomized requests checked against a word-array model.
module tb_dmem_ctrl;

  localparam int unsigned AW = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          we;
  logic [1:0]    size;
  logic          sext;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          ready;
  logic          ack;
  logic          err;
  logic [31:0]   rdata;
  logic [AW-1:0] err_addr;
  logic          ram_ena;
  logic          ram_wena;
  logic [19:0]   ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  // Bench-side RAM with a preload port so one process owns the array.
  logic [31:0]   ram [0:(1<<20)-1];
  logic          pl_en = 1'b0;
  logic [19:0]   pl_addr = '0;
  logic [31:0]   pl_data = '0;

  int unsigned   total = 0;
  int unsigned   bad = 0;
  int unsigned   ack_seen = 0;
  int unsigned   issued = 0;

  // Reference model state
  logic [31:0]   mdl [64];
  logic [31:0]   exp_rd;
  logic [AW-1:0] exp_ea;

  typedef struct {
    logic          we;
    logic [1:0]    size;
    logic          sext;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          err;
    logic [31:0]   rdata;
    int unsigned   lat;
    logic [AW-1:0] eaddr;
  } vec_t;

  vec_t tbl [14];

  dmem_ctrl #(.DEPTH(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .we_i        (we),
    .size_i      (size),
    .sext_i      (sext),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .ready_o     (ready),
    .ack_o       (ack),
    .err_o       (err),
    .rdata_o     (rdata),
    .err_addr_o  (err_addr),
    .ram_ena_o   (ram_ena),
    .ram_wena_o  (ram_wena),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  always #5 clk = ~clk;

  assign ram_rdata = ram[ram_addr];

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ram_ena && ram_wena) ram[ram_addr] <= ram_wdata;
  end

  always @(negedge clk) begin
    if (ack) ack_seen <= ack_seen + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic int unsigned nbits_of(input logic [1:0] s);
    return (s == 2'b00) ? 8 : (s == 2'b01) ? 16 : 32;
  endfunction

  function automatic bit m_mis(input logic [1:0] s, input logic [AW-1:0] a);
    return (s == 2'b11) || (s == 2'b01 && a % 2 != 0) || (s == 2'b10 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] s,
                                         input bit sx, input logic [1:0] off);
    int unsigned n = nbits_of(s);
    logic [31:0] msk;
    logic [31:0] v;
    if (n == 32) return w;
    msk = (32'h1 << n) - 1;
    v = (w >> (8 * off)) & msk;
    if (sx && ((v >> (n - 1)) & 32'h1) != 0) v = v | ~msk;
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [1:0] s,
                                          input logic [1:0] off, input logic [31:0] d);
    int unsigned n = nbits_of(s);
    logic [31:0] msk;
    if (n == 32) return d;
    msk = ((32'h1 << n) - 1) << (8 * off);
    return (w & ~msk) | ((d << (8 * off)) & msk);
  endfunction

  function automatic int unsigned m_lat(input bit w, input logic [1:0] s, input logic [AW-1:0] a);
    if (m_mis(s, a)) return 1;
    if (!w || s == 2'b10) return 2;
    return 3;
  endfunction

  task automatic preload(input int unsigned widx, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = widx[19:0];
    pl_data = d;
    @(posedge clk); #1;
    pl_en   = 1'b0;
    mdl[widx] = d;
  endtask

  // Present one request now and follow it to its ack; returns inside the ack cycle.
  task automatic txn(input bit w, input logic [1:0] s, input bit sx, input logic [AW-1:0] a,
                     input logic [31:0] wd, input bit hold, input bit x_err,
                     input logic [31:0] x_rd, input int unsigned x_lat,
                     input logic [AW-1:0] x_ea, input string nm);
    chk({nm, ".ready"}, 64'(ready), 64'(1));
    req = 1'b1; we = w; size = s; sext = sx; addr = a; wdata = wd;
    for (int unsigned c = 1; c <= x_lat; c++) begin
      @(posedge clk); #1;
      if (!hold || c == x_lat) req = 1'b0;
      if (x_err) chk({nm, ".ram_ena"}, 64'(ram_ena), 64'(0));
      if (c < x_lat) begin
        chk({nm, ".early_ack"}, 64'(ack), 64'(0));
      end else begin
        chk({nm, ".ack"}, 64'(ack), 64'(1));
        chk({nm, ".err"}, 64'(err), 64'(x_err));
        chk({nm, ".rdata"}, 64'(rdata), 64'(x_rd));
        chk({nm, ".err_addr"}, 64'(err_addr), 64'(x_ea));
      end
    end
    issued++;
  endtask

  // Model-predicted request; updates model state.
  task automatic mtxn(input bit w, input logic [1:0] s, input bit sx, input logic [AW-1:0] a,
                      input logic [31:0] wd, input bit hold, input string nm);
    bit mis = m_mis(s, a);
    int unsigned wi = int'(a[7:2]);
    if (mis) exp_ea = a;
    else if (!w) exp_rd = m_load(mdl[wi], s, sx, a[1:0]);
    txn(w, s, sx, a, wd, hold, mis, exp_rd, m_lat(w, s, a), exp_ea, nm);
    if (!mis && w) mdl[wi] = m_store(mdl[wi], s, a[1:0], wd);
  endtask

  initial begin
    int unsigned acks_before;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = '0; sext = 1'b0; addr = '0; wdata = '0;
    exp_rd = '0; exp_ea = '0;

    // Directed vectors
    //             we    size   sx    addr      wdata          err   rdata          lat ea
    tbl[0]  = '{1'b1, 2'b00, 1'b0, 22'h12, 32'h000000AB, 1'b0, 32'h00000000, 2, 22'h0};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 22'h10, 32'h0,        1'b0, 32'h11AB3344, 2, 22'h0};
    tbl[2]  = '{1'b1, 2'b10, 1'b0, 22'h10, 32'hDEADBEEF, 1'b0, 32'h11AB3344, 2, 22'h0};
    tbl[3]  = '{1'b0, 2'b10, 1'b0, 22'h10, 32'h0,        1'b0, 32'hDEADBEEF, 2, 22'h0};
    tbl[4]  = '{1'b0, 2'b00, 1'b1, 22'h02, 32'h0,        1'b0, 32'hFFFFFFFF, 2, 22'h0};
    tbl[5]  = '{1'b0, 2'b01, 1'b0, 22'h02, 32'h0,        1'b0, 32'h000080FF, 2, 22'h0};
    tbl[6]  = '{1'b0, 2'b00, 1'b1, 22'h03, 32'h0,        1'b0, 32'hFFFFFF80, 2, 22'h0};
    tbl[7]  = '{1'b0, 2'b00, 1'b1, 22'h00, 32'h0,        1'b0, 32'h00000001, 2, 22'h0};
    tbl[8]  = '{1'b0, 2'b01, 1'b1, 22'h00, 32'h0,        1'b0, 32'h00007F01, 2, 22'h0};
    tbl[9]  = '{1'b0, 2'b01, 1'b0, 22'h05, 32'h0,        1'b1, 32'h00007F01, 1, 22'h5};
    tbl[10] = '{1'b1, 2'b10, 1'b0, 22'h06, 32'h12345678, 1'b1, 32'h00007F01, 1, 22'h6};
    tbl[11] = '{1'b0, 2'b11, 1'b0, 22'h00, 32'h0,        1'b1, 32'h00007F01, 1, 22'h0};
    tbl[12] = '{1'b1, 2'b01, 1'b0, 22'h12, 32'h1234CAFE, 1'b0, 32'h00007F01, 3, 22'h0};
    tbl[13] = '{1'b0, 2'b01, 1'b1, 22'h12, 32'h0,        1'b0, 32'hFFFFCAFE, 2, 22'h0};
    tbl[0].lat = 3;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 64'(ready), 64'(1));
    chk("rst.ack", 64'(ack), 64'(0));
    chk("rst.err", 64'(err), 64'(0));
    chk("rst.rdata", 64'(rdata), 64'(0));
    chk("rst.err_addr", 64'(err_addr), 64'(0));
    chk("rst.ram_ena", 64'(ram_ena), 64'(0));
    rst = 1'b0;

    for (int unsigned i = 0; i < 64; i++) preload(i, $urandom);
    preload(0, 32'h80FF7F01);
    preload(1, 32'h55667788);
    preload(4, 32'h11223344);
    @(posedge clk); #1;

    for (int unsigned i = 0; i < 14; i++) begin
      txn(tbl[i].we, tbl[i].size, tbl[i].sext, tbl[i].addr, tbl[i].wdata, 1'b0,
          tbl[i].err, tbl[i].rdata, tbl[i].lat, tbl[i].eaddr, $sformatf("vec%0d", i));
      if (!m_mis(tbl[i].size, tbl[i].addr) && tbl[i].we)
        mdl[tbl[i].addr[7:2]] = m_store(mdl[tbl[i].addr[7:2]], tbl[i].size,
                                        tbl[i].addr[1:0], tbl[i].wdata);
      exp_rd = tbl[i].rdata;
      exp_ea = tbl[i].eaddr;
      @(posedge clk); #1;
    end
    chk("ram.word4", 64'(ram[4]), 64'(32'hCAFEBEEF));
    chk("ram.word1", 64'(ram[1]), 64'(32'h55667788));

    // Reset during WRITE of a halfword store to word 8
    acks_before = ack_seen;
    req = 1'b1; we = 1'b1; size = 2'b01; sext = 1'b0; addr = 22'h20; wdata = 32'h0000A5A5;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("abort.in_write", 64'(ram_wena), 64'(1));
    rst = 1'b1;
    #1;
    chk("abort.ready", 64'(ready), 64'(1));
    chk("abort.outs", {ack, err, ram_ena, ram_wena, rdata}, 64'(0));
    chk("abort.addrs", {err_addr, ram_addr, ram_wdata}, 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd = '0; exp_ea = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort.ready_after", 64'(ready), 64'(1));
    chk("abort.no_ack", 64'(ack_seen), 64'(acks_before));
    chk("abort.word8", 64'(ram[8]), 64'(mdl[8]));

    // Back-to-back mixed requests, one load with req held through its busy cycle
    mtxn(1'b1, 2'b10, 1'b0, 22'h40, 32'hF00D8421, 1'b0, "b2b0");
    mtxn(1'b0, 2'b00, 1'b1, 22'h41, 32'h0,        1'b1, "b2b1");
    mtxn(1'b1, 2'b01, 1'b0, 22'h42, 32'h00007766, 1'b0, "b2b2");
    mtxn(1'b0, 2'b10, 1'b0, 22'h40, 32'h0,        1'b1, "b2b3");
    repeat (3) @(posedge clk);
    #1;
    chk("b2b.ack_count", 64'(ack_seen), 64'(issued));

    // Randomized requests against the model
    for (int unsigned i = 0; i < 150; i++) begin
      bit          w  = 1'($urandom_range(0, 1));
      logic [1:0]  s  = 2'($urandom_range(0, 3));
      bit          sx = 1'($urandom_range(0, 1));
      logic [AW-1:0] a = AW'($urandom_range(0, 255));
      bit          h  = !w && ($urandom_range(0, 1) == 1);
      mtxn(w, s, sx, a, $urandom, h, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int unsigned i = 0; i < 64; i += 9) chk($sformatf("final.word%0d", i), 64'(ram[i]), 64'(mdl[i]));
    chk("final.ack_count", 64'(ack_seen), 64'(issued));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
